riscv_wbu: RTL

Writeback unit of the NPC core, directly upstream of the register file write port. It accepts one completed instruction per handshake from execute, passes ALU results straight through, and for loads issues a word-aligned data-memory read, extracts and sign/zero-extends the addressed byte, halfword or word, and then drives a single-cycle register write. It also reports the pending destination register so the decode stage can stall on load-use hazards.

---
 rtl/riscv_wbu_if.sv | 29 ++
 rtl/riscv_wbu.sv | 119 +++++++++++
 2 files changed

// File: rtl/riscv_wbu_if.sv
// rtl/riscv_wbu_if.sv - execute-side and data-memory handshake bundle for the writeback unit
interface riscv_wbu_if #(
    parameter int XLEN = 32
);
    logic            ex_valid_i;
    logic            ex_ready_o;
    logic            ex_rd_we_i;
    logic [4:0]      ex_rd_idx_i;
    logic            ex_is_load_i;
    logic [2:0]      ex_funct3_i;
    logic [XLEN-1:0] ex_result_i;
    logic            mem_req_o;
    logic [XLEN-1:0] mem_addr_o;
    logic            mem_gnt_i;
    logic            mem_rvalid_i;
    logic [XLEN-1:0] mem_rdata_i;

    modport slave (
        input  ex_valid_i, ex_rd_we_i, ex_rd_idx_i, ex_is_load_i, ex_funct3_i, ex_result_i,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output ex_ready_o, mem_req_o, mem_addr_o
    );

    modport master (
        output ex_valid_i, ex_rd_we_i, ex_rd_idx_i, ex_is_load_i, ex_funct3_i, ex_result_i,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  ex_ready_o, mem_req_o, mem_addr_o
    );
endinterface

// File: rtl/riscv_wbu.sv
// rtl/riscv_wbu.sv - writeback unit: ALU passthrough, load access/extraction, rd write pulse
module riscv_wbu #(
    parameter int XLEN = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    riscv_wbu_if.slave       bus,
    output logic             rd_we_o,
    output logic [4:0]       rd_idx_o,
    output logic [XLEN-1:0]  rd_val_o,
    output logic             load_err_o,
    output logic             busy_o,
    output logic [4:0]       busy_rd_o
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, WB} state_t;

    state_t          state;
    logic            mem_req;
    logic [XLEN-1:0] mem_addr;
    logic [4:0]      ld_idx;
    logic            ld_we;
    logic [2:0]      ld_f3;
    logic [1:0]      ld_off;
    logic [XLEN-1:0] ld_data;
    logic [7:0]      byte_v;
    logic [15:0]     half_v;
    logic            wr_nonzero;
    logic            ld_illegal;
    logic            ld_misalign;

    assign bus.ex_ready_o = rst_n && (state == IDLE || state == WB);
    assign bus.mem_req_o  = mem_req;
    assign bus.mem_addr_o = mem_addr;

    assign wr_nonzero  = bus.ex_rd_we_i && (bus.ex_rd_idx_i != 5'd0);
    assign ld_illegal  = (bus.ex_funct3_i == 3'b011) || (bus.ex_funct3_i[2:1] == 2'b11);
    assign ld_misalign = ((bus.ex_funct3_i[1:0] == 2'b01) && bus.ex_result_i[0]) ||
                         ((bus.ex_funct3_i == 3'b010) && (bus.ex_result_i[1:0] != 2'b00));

    // funct3[2] selects zero-extension for the byte/halfword cases
    always_comb begin
        byte_v  = bus.mem_rdata_i[{ld_off, 3'b000} +: 8];
        half_v  = bus.mem_rdata_i[{ld_off[1], 4'b0000} +: 16];
        ld_data = bus.mem_rdata_i;
        case (ld_f3[1:0])
            2'b00:   ld_data = {{(XLEN-8){~ld_f3[2] & byte_v[7]}}, byte_v};
            2'b01:   ld_data = {{(XLEN-16){~ld_f3[2] & half_v[15]}}, half_v};
            default: ld_data = bus.mem_rdata_i;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            ld_idx     <= 5'd0;
            ld_we      <= 1'b0;
            ld_f3      <= 3'b000;
            ld_off     <= 2'b00;
            rd_we_o    <= 1'b0;
            rd_idx_o   <= 5'd0;
            rd_val_o   <= '0;
            load_err_o <= 1'b0;
            busy_o     <= 1'b0;
            busy_rd_o  <= 5'd0;
        end else begin
            rd_we_o    <= 1'b0;
            load_err_o <= 1'b0;
            case (state)
                IDLE, WB: begin
                    state <= IDLE;
                    if (bus.ex_valid_i) begin
                        if (!bus.ex_is_load_i) begin
                            state   <= WB;
                            rd_we_o <= wr_nonzero;
                            // rd_idx_o/rd_val_o only move when a real write happens
                            if (wr_nonzero) begin
                                rd_idx_o <= bus.ex_rd_idx_i;
                                rd_val_o <= bus.ex_result_i;
                            end
                        end else if (ld_illegal || ld_misalign) begin
                            load_err_o <= 1'b1;
                        end else begin
                            state     <= REQ;
                            mem_req   <= 1'b1;
                            mem_addr  <= {bus.ex_result_i[XLEN-1:2], 2'b00};
                            ld_idx    <= bus.ex_rd_idx_i;
                            ld_we     <= wr_nonzero;
                            ld_f3     <= bus.ex_funct3_i;
                            ld_off    <= bus.ex_result_i[1:0];
                            busy_o    <= 1'b1;
                            busy_rd_o <= wr_nonzero ? bus.ex_rd_idx_i : 5'd0;
                        end
                    end
                end
                REQ: begin
                    if (bus.mem_gnt_i) begin
                        mem_req <= 1'b0;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.mem_rvalid_i) begin
                        state     <= WB;
                        busy_o    <= 1'b0;
                        busy_rd_o <= 5'd0;
                        rd_we_o   <= ld_we;
                        if (ld_we) begin
                            rd_idx_o <= ld_idx;
                            rd_val_o <= ld_data;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
